// File: rtl/reaction_control.sv
// reaction_control: sequencing FSM for the reaction-time game; debounces the button,
//   drives the datapath strobes, detects false starts and no-response timeouts.
// Latency: raw button edge -> press event = 2 + DEBOUNCE_CYC + 1 cycles, state moves next edge.
// Backpressure: none; all inputs are levels sampled every cycle, all outputs registered.
// Ports:
//   clk, iReset (async, active-high)      iButton (raw, async), iCountComplete (level)
//   oStart_down_count / oStart_up_count    held START_HOLD cycles after ARM / GO entry
//   oLoad_score (1-cycle pulse)           oScreen: 0 idle, 1 wait, 2 go, 3 result
//   oFalse_start (FALSE state)            oTimeout (RESULT reached by timeout)
module reaction_control #(
  parameter int CLK_PER_MS   = 50000,
  parameter int TIMEOUT_MS   = 4000,
  parameter int START_HOLD   = 64,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iButton,
  input  logic       iCountComplete,
  output logic       oStart_down_count,
  output logic       oStart_up_count,
  output logic       oLoad_score,
  output logic [1:0] oScreen,
  output logic       oFalse_start,
  output logic       oTimeout
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int PRE_W  = $clog2(CLK_PER_MS + 1);
  localparam int MS_W   = $clog2(TIMEOUT_MS + 1);
  localparam int HOLD_W = $clog2(START_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_GO, S_LOAD, S_RESULT, S_FALSE
  } state_t;

  state_t            r_state;
  logic              r_sync1, r_sync2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_btn_lvl, r_btn_lvl_d, r_press;
  logic [PRE_W-1:0]  r_pre;
  logic [MS_W-1:0]   r_ms;
  logic [HOLD_W-1:0] r_hold;
  logic              r_down, r_up, r_load, r_false, r_timeout;
  logic [1:0]        r_screen;

  logic w_btn_diff, w_pre_wrap, w_timeout;

  assign w_btn_diff = r_sync2 ^ r_btn_lvl;
  assign w_pre_wrap = (r_pre == PRE_W'(CLK_PER_MS - 1));
  // Fires on the edge where the ms counter steps onto TIMEOUT_MS, so the
  // LOAD edge lands exactly TIMEOUT_MS*CLK_PER_MS cycles after GO entry.
  assign w_timeout  = w_pre_wrap && (r_ms == MS_W'(TIMEOUT_MS - 1));

  // Button: synchronizer, debounce, rising-edge press pulse.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_db_cnt    <= '0;
      r_btn_lvl   <= 1'b0;
      r_btn_lvl_d <= 1'b0;
      r_press     <= 1'b0;
    end else begin
      r_sync1 <= iButton;
      r_sync2 <= r_sync1;
      if (!w_btn_diff) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        r_db_cnt  <= '0;
        r_btn_lvl <= ~r_btn_lvl;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      r_btn_lvl_d <= r_btn_lvl;
      r_press     <= r_btn_lvl & ~r_btn_lvl_d;
    end
  end

  // ms timer: prescaler + saturating ms counter, both parked at 0 outside GO.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (r_state == S_GO) begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
      if (w_pre_wrap && (r_ms != MS_W'(TIMEOUT_MS)))
        r_ms <= r_ms + 1'b1;
    end else begin
      r_pre <= '0;
      r_ms  <= '0;
    end
  end

  // Game FSM with registered outputs.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_down    <= 1'b0;
      r_up      <= 1'b0;
      r_load    <= 1'b0;
      r_false   <= 1'b0;
      r_timeout <= 1'b0;
      r_screen  <= 2'd0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: if (r_press) begin
          r_state  <= S_ARM;
          r_screen <= 2'd1;
          r_hold   <= '0;
        end
        S_ARM: begin
          // iCountComplete is deliberately not looked at here: the datapath
          // may still show zero before it has seen the reload.
          if (r_press) begin
            r_state  <= S_FALSE;
            r_screen <= 2'd3;
            r_false  <= 1'b1;
            r_down   <= 1'b0;
          end else if (r_hold == HOLD_W'(START_HOLD)) begin
            r_state <= S_WAIT;
            r_down  <= 1'b0;
          end else begin
            r_hold <= r_hold + 1'b1;
            r_down <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_press) begin
            r_state  <= S_FALSE;
            r_screen <= 2'd3;
            r_false  <= 1'b1;
          end else if (iCountComplete) begin
            r_state  <= S_GO;
            r_screen <= 2'd2;
            r_hold   <= '0;
          end
        end
        S_GO: begin
          if (r_press || w_timeout) begin
            r_state   <= S_LOAD;
            r_screen  <= 2'd3;
            r_up      <= 1'b0;
            r_load    <= 1'b1;
            r_timeout <= ~r_press; // a coincident press is a valid reaction
          end else if (r_hold != HOLD_W'(START_HOLD)) begin
            r_hold <= r_hold + 1'b1;
            r_up   <= 1'b1;
          end else begin
            r_up <= 1'b0;
          end
        end
        S_LOAD: r_state <= S_RESULT;
        S_RESULT: if (r_press) begin
          r_state   <= S_IDLE;
          r_screen  <= 2'd0;
          r_timeout <= 1'b0;
        end
        S_FALSE: if (r_press) begin
          r_state  <= S_IDLE;
          r_screen <= 2'd0;
          r_false  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_screen <= 2'd0;
        end
      endcase
    end
  end

  assign oStart_down_count = r_down;
  assign oStart_up_count   = r_up;
  assign oLoad_score       = r_load;
  assign oScreen           = r_screen;
  assign oFalse_start      = r_false;
  assign oTimeout          = r_timeout;

endmodule
